// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle for pipe_reg_chain: producer side, consumer side, flush and occupancy.
// The slave modport is the chain's own view; master is the view of whoever drives it.
interface pipe_reg_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Elastic chain of DEPTH valid/ready register stages with bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_reg_chain #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  pipe_reg_chain_if.slave     bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            v_all;
  logic [DEPTH-1:0][WIDTH-1:0] d_all;
  logic [DEPTH:0]              go;
  logic                        in_xfer;
  logic                        out_xfer;
  logic [CW-1:0]               count_q;
  logic [CW-1:0]               count_d;

  // Ready ripples from the output back to the input in a single combinational pass.
  always_comb begin
    go        = '0;
    go[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      go[i] = !v_all[i] || go[i+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             v_q;
      logic             v_d;
      logic [WIDTH-1:0] d_q;
      logic [WIDTH-1:0] d_d;
      logic             up_v;
      logic [WIDTH-1:0] up_d;

      if (gi == 0) begin : g_head
        assign up_v = bus.in_valid;
        assign up_d = bus.in_data;
      end else begin : g_body
        assign up_v = v_all[gi-1];
        assign up_d = d_all[gi-1];
      end

      // Payload only moves with a valid item, so empty stages keep stale data.
      always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (bus.flush) begin
          v_d = 1'b0;
        end else if (go[gi]) begin
          v_d = up_v;
          if (up_v) begin
            d_d = up_d;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_q <= 1'b0;
          d_q <= RESET_VAL;
        end else begin
          v_q <= v_d;
          d_q <= d_d;
        end
      end

      assign v_all[gi] = v_q;
      assign d_all[gi] = d_q;
    end
  endgenerate

  assign bus.in_ready  = go[0] && !bus.flush;
  assign bus.out_valid = v_all[DEPTH-1] && !bus.flush;
  assign bus.out_data  = d_all[DEPTH-1];

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.count = count_q;
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: directed scenarios then random traffic,
// compared each cycle against a queue of items with their current stage positions.
module tb_pipe_reg_chain;
  localparam int               WIDTH = 8;
  localparam int               DEPTH = 4;
  localparam logic [WIDTH-1:0] RV    = 8'hA5;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipe_reg_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: items oldest-first, each with the stage index it occupies.
  logic [WIDTH-1:0] q_data[$];
  int               q_pos[$];
  logic [WIDTH-1:0] last_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_data.delete();
    q_pos.delete();
    last_out = RV;
  endtask

  // One cycle: drive inputs, check outputs against prediction, advance the model.
  task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                      input logic fl, output logic acc);
    int   lim;
    int   np[$];
    logic e_ov;
    logic e_ir;
    logic oxf;
    int   first;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.flush     = fl;
    e_ov  = !fl && (q_pos.size() > 0) && (q_pos[0] == DEPTH - 1);
    oxf   = e_ov && ordy;
    first = oxf ? 1 : 0;
    lim   = DEPTH - 1;
    np    = {};
    // Each item advances one stage if the slot ahead is free after the items ahead moved.
    for (int k = first; k < q_pos.size(); k++) begin
      int p;
      p = q_pos[k] + 1;
      if (p > lim) p = lim;
      np.push_back(p);
      lim = p - 1;
    end
    e_ir = !fl && (lim >= 0);
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(e_ir));
    check("out_valid", 32'(bus.out_valid), 32'(e_ov));
    check("out_data", 32'(bus.out_data), 32'(last_out));
    check("count", 32'(bus.count), 32'(q_pos.size()));
    acc = iv && e_ir;
    $display("step iv=%0d id=%02h ordy=%0d fl=%0d | ir=%0d ov=%0d od=%02h cnt=%0d",
             iv, id, ordy, fl, bus.in_ready, bus.out_valid, bus.out_data, bus.count);
    @(posedge clk);
    if (fl) begin
      q_data.delete();
      q_pos.delete();
    end else begin
      if (oxf) begin
        void'(q_data.pop_front());
        void'(q_pos.pop_front());
      end
      q_pos = np;
      if (acc) begin
        q_data.push_back(id);
        q_pos.push_back(0);
      end
      if (q_pos.size() > 0 && q_pos[0] == DEPTH - 1) last_out = q_data[0];
    end
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    int   lat;
    bit   seen;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    model_reset();

    // Reset state
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'(RV));
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Streaming at full rate: latency and steady-state occupancy
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i + 1), 1'b1, 1'b0, acc);
      if (!seen && bus.out_valid) begin
        seen = 1'b1;
        lat  = i;
      end
      if (i == 10) check("steady_count", 32'(bus.count), 32'(DEPTH));
    end
    check("latency", 32'(lat), 32'(DEPTH - 1));
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Fill under backpressure, hold, then drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0, acc);
    check("full_count", 32'(bus.count), 32'(DEPTH));
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    step(1'b1, 8'h05, 1'b0, 1'b0, acc);
    check("full_reject", 32'(acc), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("hold_data", 32'(bus.out_data), 32'h01);
    step(1'b1, 8'h05, 1'b1, 1'b0, acc);
    check("full_pass_accept", 32'(acc), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Bubble collapse, then flush with concurrent in/out requests
    step(1'b1, 8'h11, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    step(1'b1, 8'h22, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("bubble_count", 32'(bus.count), 32'd2);
    step(1'b1, 8'h33, 1'b0, 1'b0, acc);
    check("bubble_accept", 32'(acc), 32'd1);
    step(1'b1, 8'h44, 1'b1, 1'b1, acc);
    check("flush_no_accept", 32'(acc), 32'd0);
    check("flush_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, acc);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_data", 32'(bus.out_data), 32'(RV));
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 8'h77, 1'b1, 1'b0, acc);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom()),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
